// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the ARM pipeline hazard controller.
//   sb_entry_t  : one scoreboard entry (valid, wb_en, mem_r, dest, s)
//   NZCV_*      : bit positions of the N, Z, C, V flags in a 4-bit status word
//   FWD_SEL_*   : forward-select encoding (0 = register file, k = stage k, 1 = EX)
//   sb_live()   : entry will write the register file (valid & wb_en)
package arm_pkg;

  // Widest register address the scoreboard can hold; narrower RAW is zero-extended.
  localparam int unsigned SB_DEST_W = 8;

  localparam int unsigned NZCV_W = 4;
  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  localparam int unsigned FWD_SEL_RF = 0;
  localparam int unsigned FWD_SEL_EX = 1;

  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic                 mem_r;
    logic [SB_DEST_W-1:0] dest;
    logic                 s;
  } sb_entry_t;

  function automatic logic sb_live(input sb_entry_t e);
    return e.valid & e.wb_en;
  endfunction

endpackage

// File: rtl/arm_sb_match.sv
// arm_sb_match: compares one source register against every scoreboard entry
// and reports the youngest (lowest stage index) live producer.
// Ports:
//   src    : source register address from ID
//   en     : source is actually read this cycle
//   live   : per-entry valid & wb_en, bit 0 = EX
//   dest   : per-entry destination address, element 0 = EX
//   hit_c  : some live entry writes src (combinational)
//   idx_c  : stage index of the youngest match, 0 when no hit (combinational)
module arm_sb_match
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RAW   = 4
) (
  input  logic [RAW-1:0]                      src,
  input  logic                                en,
  input  logic [DEPTH-1:0]                    live,
  input  logic [DEPTH-1:0][SB_DEST_W-1:0]     dest,
  output logic                                hit_c,
  output logic [$clog2(DEPTH+1)-1:0]          idx_c
);

  localparam int unsigned SELW = $clog2(DEPTH + 1);

  // Walk oldest to youngest so the last assignment wins with the youngest producer.
  always_comb begin
    hit_c = 1'b0;
    idx_c = SELW'(FWD_SEL_RF);
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (en && live[k] && (dest[k] == SB_DEST_W'(src))) begin
        hit_c = 1'b1;
        idx_c = SELW'(FWD_SEL_EX + k);
      end
    end
  end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// arm_pipe_ctrl: hazard / forwarding / status controller for an in-order ARM
// pipeline. A DEPTH-entry scoreboard (entry 1 = EX) tracks instructions issued
// from ID; freeze, flush and fwd_sel are derived combinationally from it.
// Build option: define ARM_FWD_EN to enable operand forwarding (only a
// load in EX then stalls ID); without it any in-flight producer stalls ID.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   id_*              : instruction currently in ID (sources, dest, control)
//   ex_status_in      : NZCV produced by the ALU for the EX instruction
//   branch_taken      : EX resolves a taken branch
//   freeze, flush     : ID stall and younger-stage kill (combinational)
//   fwd_sel1/2        : operand source, 0 = register file, k = stage k (comb.)
//   status            : architectural NZCV (registered)
//   inflight          : number of live write-back entries (registered)
// DEPTH must lie in 2..6 and RAW must not exceed arm_pkg::SB_DEST_W.
module arm_pipe_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RAW   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [RAW-1:0]              id_src1,
  input  logic [RAW-1:0]              id_src2,
  input  logic                        id_two_src,
  input  logic                        id_wb_en,
  input  logic                        id_mem_r_en,
  input  logic                        id_s,
  input  logic [RAW-1:0]              id_dest,
  input  logic [3:0]                  ex_status_in,
  input  logic                        branch_taken,
  output logic                        freeze,
  output logic                        flush,
  output logic [3:0]                  status,
  output logic [$clog2(DEPTH+1)-1:0]  fwd_sel1,
  output logic [$clog2(DEPTH+1)-1:0]  fwd_sel2,
  output logic [$clog2(DEPTH+1)-1:0]  inflight
);

  localparam int unsigned SELW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0]           sb_q;
  sb_entry_t [DEPTH-1:0]           sb_d;
  logic      [DEPTH-1:0]           live;
  logic      [DEPTH-1:0][SB_DEST_W-1:0] dests;
  logic      [SELW-1:0]            inflight_d;
  logic      [NZCV_W-1:0]          status_d;
  logic                            status_upd;

  logic                            hit1;
  logic                            hit2;
  logic      [SELW-1:0]            idx1;
  logic      [SELW-1:0]            idx2;
  logic                            hazard_c;
  logic      [SELW-1:0]            fwd1_c;
  logic      [SELW-1:0]            fwd2_c;

  // Flatten the scoreboard into what the matchers need.
  always_comb begin
    live  = '0;
    dests = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      live[k]  = sb_live(sb_q[k]);
      dests[k] = sb_q[k].dest;
    end
  end

  arm_sb_match #(.DEPTH(DEPTH), .RAW(RAW)) u_match1 (
    .src   (id_src1),
    .en    (1'b1),
    .live  (live),
    .dest  (dests),
    .hit_c (hit1),
    .idx_c (idx1)
  );

  arm_sb_match #(.DEPTH(DEPTH), .RAW(RAW)) u_match2 (
    .src   (id_src2),
    .en    (id_two_src),
    .live  (live),
    .dest  (dests),
    .hit_c (hit2),
    .idx_c (idx2)
  );

`ifdef ARM_FWD_EN
  // Everything forwards except a load still in EX: its data is not yet back.
  always_comb begin
    hazard_c = 1'b0;
    fwd1_c   = idx1;
    fwd2_c   = idx2;
    if (sb_q[0].mem_r &&
        ((hit1 && (idx1 == SELW'(FWD_SEL_EX))) ||
         (hit2 && (idx2 == SELW'(FWD_SEL_EX))))) begin
      hazard_c = 1'b1;
    end
  end
`else
  // No bypass network: any in-flight producer of a source stalls ID.
  always_comb begin
    hazard_c = hit1 | hit2;
    fwd1_c   = SELW'(FWD_SEL_RF);
    fwd2_c   = SELW'(FWD_SEL_RF);
  end

  logic unused_fwd_idx;
  assign unused_fwd_idx = ^{idx1, idx2};
`endif

  // Control outputs; a taken branch is older than ID, so it overrides a stall.
  always_comb begin
    flush    = 1'b0;
    freeze   = 1'b0;
    fwd_sel1 = SELW'(FWD_SEL_RF);
    fwd_sel2 = SELW'(FWD_SEL_RF);
    if (rst) begin
      flush    = branch_taken;
      freeze   = id_valid & hazard_c & ~branch_taken;
      fwd_sel1 = fwd1_c;
      fwd_sel2 = fwd2_c;
    end
  end

  // Scoreboard shift; entry 1 takes the ID instruction or a bubble.
  always_comb begin
    sb_d = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (id_valid && !freeze && !branch_taken) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].wb_en = id_wb_en;
      sb_d[0].mem_r = id_mem_r_en;
      sb_d[0].dest  = SB_DEST_W'(id_dest);
      sb_d[0].s     = id_s;
    end
  end

  // Live write-back count of the next scoreboard, so inflight tracks sb_q.
  always_comb begin
    inflight_d = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      inflight_d = inflight_d + SELW'(sb_live(sb_d[k]));
    end
  end

  // Flags are latched from the ALU only for a flag-setting instruction in EX.
  always_comb begin
    status_upd = sb_q[0].valid & sb_q[0].s;
    status_d   = {ex_status_in[NZCV_N], ex_status_in[NZCV_Z],
                  ex_status_in[NZCV_C], ex_status_in[NZCV_V]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q     <= '0;
      status   <= '0;
      inflight <= '0;
    end else begin
      sb_q     <= sb_d;
      inflight <= inflight_d;
      if (status_upd) begin
        status <= status_d;
      end
    end
  end

  // The retiring entry's load and flag bits have no consumer.
  logic unused_retire_bits;
  assign unused_retire_bits = ^{sb_q[DEPTH-1].mem_r, sb_q[DEPTH-1].s};

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// tb_arm_pipe_ctrl: directed scenarios plus randomized stimulus for
// arm_pipe_ctrl, checked against an instruction-history reference model.
// Honors ARM_FWD_EN the same way as the design.
module tb_arm_pipe_ctrl;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned RAW   = 4;
  localparam int unsigned SELW  = $clog2(DEPTH + 1);

`ifdef ARM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [RAW-1:0]  id_src1;
  logic [RAW-1:0]  id_src2;
  logic            id_two_src;
  logic            id_wb_en;
  logic            id_mem_r_en;
  logic            id_s;
  logic [RAW-1:0]  id_dest;
  logic [3:0]      ex_status_in;
  logic            branch_taken;
  logic            freeze;
  logic            flush;
  logic [3:0]      status;
  logic [SELW-1:0] fwd_sel1;
  logic [SELW-1:0] fwd_sel2;
  logic [SELW-1:0] inflight;

  arm_pipe_ctrl #(.DEPTH(DEPTH), .RAW(RAW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .id_s         (id_s),
    .id_dest      (id_dest),
    .ex_status_in (ex_status_in),
    .branch_taken (branch_taken),
    .freeze       (freeze),
    .flush        (flush),
    .status       (status),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .inflight     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every issued instruction with the cycle it left ID.
  // Its pipeline stage is simply (current cycle - issue cycle).
  typedef struct {
    int         issue;
    logic       wb;
    logic       mr;
    logic [3:0] dest;
    logic       s;
  } instr_t;

  instr_t     hist[$];
  int         cyc;
  logic [3:0] status_m;
  int         inflight_m;

  int tests;
  int fails;

  logic       seen_freeze;
  logic       seen_flush;
  int         seen_fwd1;
  int         seen_inflight;
  logic [3:0] seen_status;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  // Youngest in-flight writer of src, as its stage number.
  function automatic void youngest(input logic [3:0] src, input logic en,
                                   output logic hit, output int age, output logic mr);
    hit = 1'b0;
    age = 0;
    mr  = 1'b0;
    if (en) begin
      foreach (hist[i]) begin
        int a;
        a = cyc - hist[i].issue;
        if (a >= 1 && a <= int'(DEPTH) && hist[i].wb && hist[i].dest == src &&
            (!hit || a < age)) begin
          hit = 1'b1;
          age = a;
          mr  = hist[i].mr;
        end
      end
    end
  endfunction

  function automatic void expect_comb(output logic ef, output logic efl,
                                      output int f1, output int f2);
    logic h1, h2, m1, m2;
    int   a1, a2;
    youngest(id_src1, 1'b1, h1, a1, m1);
    youngest(id_src2, id_two_src, h2, a2, m2);
    efl = branch_taken;
    if (FWD) begin
      f1 = h1 ? a1 : 0;
      f2 = h2 ? a2 : 0;
      ef = id_valid && !branch_taken && ((h1 && a1 == 1 && m1) || (h2 && a2 == 1 && m2));
    end else begin
      f1 = 0;
      f2 = 0;
      ef = id_valid && !branch_taken && (h1 || h2);
    end
    if (!rst) begin
      ef  = 1'b0;
      efl = 1'b0;
      f1  = 0;
      f2  = 0;
    end
  endfunction

  task automatic compare_all();
    logic ef, efl;
    int   f1, f2;
    if (!rst) begin
      hist.delete();
      status_m   = 4'b0000;
      inflight_m = 0;
    end
    expect_comb(ef, efl, f1, f2);
    seen_freeze   = freeze;
    seen_flush    = flush;
    seen_fwd1     = int'(fwd_sel1);
    seen_inflight = int'(inflight);
    seen_status   = status;
    check_val("freeze",   32'(freeze),   32'(ef));
    check_val("flush",    32'(flush),    32'(efl));
    check_val("fwd_sel1", 32'(fwd_sel1), 32'(f1));
    check_val("fwd_sel2", 32'(fwd_sel2), 32'(f2));
    check_val("status",   32'(status),   32'(status_m));
    check_val("inflight", 32'(inflight), 32'(inflight_m));
  endtask

  task automatic model_edge();
    logic ef, efl;
    int   f1, f2;
    instr_t n;
    if (!rst) return;
    expect_comb(ef, efl, f1, f2);
    foreach (hist[i]) begin
      if (cyc - hist[i].issue == 1 && hist[i].s) status_m = ex_status_in;
    end
    if (id_valid && !ef && !branch_taken) begin
      n.issue = cyc;
      n.wb    = id_wb_en;
      n.mr    = id_mem_r_en;
      n.dest  = id_dest;
      n.s     = id_s;
      hist.push_back(n);
    end
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].issue > int'(DEPTH)) void'(hist.pop_front());
    inflight_m = 0;
    foreach (hist[i]) if (hist[i].wb) inflight_m++;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic mr, input logic s,
                       input logic [3:0] d, input logic br, input logic [3:0] st);
    id_valid     = v;
    id_src1      = s1;
    id_src2      = s2;
    id_two_src   = two;
    id_wb_en     = wb;
    id_mem_r_en  = mr;
    id_s         = s;
    id_dest      = d;
    branch_taken = br;
    ex_status_in = st;
  endtask

  // Inputs were driven just after the last edge; check mid-cycle, then clock.
  task automatic run_cycle();
    #2;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      run_cycle();
    end
  endtask

  // Producer of r(dest), then a reader held in ID until it is accepted.
  task automatic hazard_seq(input logic [3:0] dest, input logic mr,
                            input int exp_nfz, input int exp_fwd);
    int nfz;
    nfz = 0;
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, mr, 1'b0, dest, 1'b0, 4'd0);
    run_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, dest, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      run_cycle();
      if (seen_freeze) nfz++;
      else break;
    end
    check_val("freeze_cycles", 32'(nfz), 32'(exp_nfz));
    check_val("fwd_at_accept", 32'(seen_fwd1), 32'(exp_fwd));
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    cyc        = 0;
    status_m   = 4'b0000;
    inflight_m = 0;
    rst        = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    run_cycle();
    check_val("reset_status", 32'(seen_status), 32'd0);
    check_val("reset_inflight", 32'(seen_inflight), 32'd0);
    // Branch during reset must not show as flush.
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 4'hF);
    run_cycle();
    check_val("reset_flush", 32'(seen_flush), 32'd0);
    rst = 1'b1;
    bubbles(2);

    // ALU producer: forwarded (EX, then MEM) or stalled three cycles.
    hazard_seq(4'd1, 1'b0, FWD ? 0 : 3, FWD ? 1 : 0);
    drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    run_cycle();
    check_val("fwd_second_reader", 32'(seen_fwd1), FWD ? 32'd2 : 32'd0);
    bubbles(4);

    // Load-use: one bubble with forwarding, full drain without.
    hazard_seq(4'd2, 1'b1, FWD ? 1 : 3, FWD ? 2 : 0);
    bubbles(4);

    // Branch beats a hazard freeze; entry 1 becomes a bubble.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0);
    run_cycle();
    drive(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 4'd0);
    run_cycle();
    check_val("branch_flush", 32'(seen_flush), 32'd1);
    check_val("branch_freeze", 32'(seen_freeze), 32'd0);
    bubbles(1);
    check_val("branch_bubble_inflight", 32'(seen_inflight), 32'd1);
    bubbles(3);

    // Flag-setting CMP latches NZCV; a non-flag instruction leaves it.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    run_cycle();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12, 1'b0, 4'b0110);
    run_cycle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'b1111);
    run_cycle();
    check_val("status_set", 32'(seen_status), 32'b0110);
    bubbles(1);
    check_val("status_hold", 32'(seen_status), 32'b0110);
    bubbles(3);

    // Reset with three live producers in flight.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 4'd0);
    run_cycle();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 4'd0);
    run_cycle();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 4'd0);
    run_cycle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    #2;
    check_val("pre_reset_inflight", 32'(inflight), 32'd3);
    rst = 1'b0;
    #1;
    check_val("mid_reset_inflight", 32'(inflight), 32'd0);
    check_val("mid_reset_status", 32'(status), 32'd0);
    run_cycle();
    rst = 1'b1;
    drive(1'b1, 4'd7, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    run_cycle();
    check_val("post_reset_fwd", 32'(seen_fwd1), 32'd0);
    check_val("post_reset_freeze", 32'(seen_freeze), 32'd0);

    // Randomized traffic with small register range to force hazards.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom % 97) != 0;
      drive(($urandom % 4) != 0, 4'($urandom % 4), 4'($urandom % 4), 1'($urandom % 2),
            ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
            4'($urandom % 4), ($urandom % 8) == 0, 4'($urandom));
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arm_pipe_ctrl.md
ARM_PIPE_CTRL -- requirements
Module: arm_pipe_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of tracked stages after ID (EX, MEM, WB); legal range 2..6.
REQ-002 SHALL have parameter RAW, default 4, register-address width.
REQ-003 SHALL have ports: clk  input  1  rising-edge clock.
REQ-004 SHALL have ports: rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: id_valid  input  1  ID holds a real instruction.
REQ-006 SHALL have ports: id_src1, id_src2  input  RAW  Rn / Rm source addresses.
REQ-007 SHALL have ports: id_two_src  input  1  id_src2 is read (register operand or store).
REQ-008 SHALL have ports: id_wb_en, id_mem_r_en, id_s  input  1 each  ID control bits.
REQ-009 SHALL have ports: id_dest  input  RAW  destination address.
REQ-010 SHALL have ports: ex_status_in  input  4  NZCV from ALU; branch_taken  input  1  EX resolves a taken branch.
REQ-011 SHALL have ports: freeze  output  1; flush  output  1; status  output  4 (NZCV).
REQ-012 SHALL have ports: fwd_sel1, fwd_sel2  output  clog2(DEPTH+1)  0 = register file, k = stage k (1 = EX).
REQ-013 SHALL have ports: inflight  output  clog2(DEPTH+1)  count of valid write-back entries.

Function
REQ-014 SHALL hold a DEPTH-entry scoreboard shift register, entry {valid, wb_en, mem_r, dest, s}; entry 1 = EX.
REQ-015 SHALL each cycle shift entry k-1 into entry k; entry DEPTH retires.
REQ-016 SHALL load entry 1 with ID fields when id_valid & ~freeze & ~branch_taken, else with a bubble (valid=0).
REQ-017 SHALL compute freeze, flush, fwd_sel combinationally in the same cycle (zero latency).
REQ-018 SHALL treat a source as matching entry k when valid & wb_en & dest==source; id_src2 only when id_two_src.
REQ-019 SHALL assert flush = branch_taken; while flush=1, freeze SHALL be 0 (branch is older, wins).
REQ-020 SHALL assert freeze only when id_valid=1 and a hazard exists per REQ-027/REQ-028.
REQ-021 SHALL, when multiple entries match, select the lowest k (youngest producer).
REQ-022 SHALL update status <= ex_status_in on a clock edge when entry 1 is valid with s=1; otherwise hold.
REQ-023 SHALL keep inflight equal to the number of entries with valid & wb_en, saturating impossible by construction.
REQ-024 SHALL on freeze keep downstream entries shifting (bubble inserted at entry 1).

Reset
REQ-025 SHALL on rst=0 asynchronously clear all scoreboard entries, status=4'b0000, inflight=0.
REQ-026 SHALL drive freeze=0, flush=0, fwd_sel1=fwd_sel2=0 while in reset; reset mid-stream discards all in-flight entries.

Configuration
REQ-027 With ARM_FWD_EN defined: fwd_sel = youngest matching k; freeze only when entry 1 matches with mem_r=1 (load-use, one bubble).
REQ-028 Without ARM_FWD_EN: fwd_sel outputs tied 0; freeze whenever any entry 1..DEPTH matches.

Structure
REQ-029 SHALL place scoreboard-entry struct, NZCV bit indices and fwd_sel encoding constants in shared package arm_pkg.
REQ-030 SHALL use one sub-module arm_sb_match (one source vs. DEPTH entries -> hit, index), instantiated twice.

Verification
REQ-031 FWD: ADD r1 issued, next ID reads r1 -> freeze=0, fwd_sel1=1; one cycle later -> fwd_sel1=2.
REQ-032 FWD: LDR r2 in EX, ID reads r2 -> freeze=1 one cycle, then fwd_sel1=2, freeze=0.
REQ-033 No FWD (DEPTH=3): ADD r3 then reader of r3 -> freeze=1 for 3 cycles, then 0.
REQ-034 Hazard freeze and branch_taken=1 same cycle -> flush=1, freeze=0, entry 1 bubble next cycle.
REQ-035 CMP with s=1, ex_status_in=4'b0110 -> status=4'b0110 after edge; s=0 instruction -> status holds.
REQ-036 rst=0 mid-stream with inflight=3 -> inflight=0, status=0 immediately, no stale forwarding after release.
